// File: rtl/fetch_pkg.sv
// fetch_pkg: shared line geometry and word types for the fetch stage
package fetch_pkg;
  localparam int LINE_WORDS = 8;
  typedef logic [31:0] word_t;
  typedef word_t [LINE_WORDS-1:0] fetch_line_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular word store with an 8-wide line write port and a 1-wide head read port
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fetch_line_t              line_i,
  output word_t                    head_word_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  word_t         mem_q [DEPTH];
  // pointer and occupancy next-state; a flush empties the queue outright
  always_comb begin
    head_d  = flush_i ? '0 : head_q + AW'(pop_i);
    tail_d  = flush_i ? '0 : tail_q + (push_i ? AW'(LINE_WORDS) : '0);
    count_d = flush_i ? '0 : count_q + (push_i ? CW'(LINE_WORDS) : '0) - CW'(pop_i);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // line write: eight consecutive slots starting at tail, wrapping modulo DEPTH
  always_ff @(posedge clk_i) begin
    if (push_i)
      for (int k = 0; k < LINE_WORDS; k++) mem_q[tail_q + AW'(k)] <= line_i[k];
  end
  assign head_word_o = mem_q[head_q];
  assign count_o     = count_q;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch PC, line fill into the instruction queue, decode issue and redirect flush
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_w0,
  input  logic [31:0]            imem_w1,
  input  logic [31:0]            imem_w2,
  input  logic [31:0]            imem_w3,
  input  logic [31:0]            imem_w4,
  input  logic [31:0]            imem_w5,
  input  logic [31:0]            imem_w6,
  input  logic [31:0]            imem_w7,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [31:0]            dec_instr,
  output logic [31:0]            dec_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [31:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d, target_pc;
  logic        fill, pop;
  fetch_line_t line;
  assign line      = {imem_w7, imem_w6, imem_w5, imem_w4, imem_w3, imem_w2, imem_w1, imem_w0};
  assign target_pc = redirect_pc & ~32'h3;
  // fill decision uses only registered count so dec_ready never reaches imem_addr
  assign fill      = !redirect && (count <= CW'(DEPTH - LINE_WORDS));
  assign dec_valid = (count != '0) && !redirect;
  assign pop       = dec_valid && dec_ready;
  // PC next-state: redirect reloads both PCs, otherwise advance by line and by word
  always_comb begin
    fetch_pc_d = redirect ? target_pc : fetch_pc_q + (fill ? 32'd32 : 32'd0);
    head_pc_d  = redirect ? target_pc : head_pc_q + (pop ? 32'd4 : 32'd0);
  end
  // PC registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
    end
  end
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i      (CLK),
    .rst_i      (RST),
    .flush_i    (redirect),
    .push_i     (fill),
    .pop_i      (pop),
    .line_i     (line),
    .head_word_o(dec_instr),
    .count_o    (count)
  );
  assign imem_addr = fetch_pc_q;
  assign dec_pc    = head_pc_q;
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch stage directly upstream of the 8-word-wide combinational instruction memory.
- Holds the fetch PC and drives the memory address. Captures whole 8-word lines into a circular instruction queue.
- Issues one instruction plus its PC per cycle to decode over a valid/ready handshake.
- Flushes and refetches on redirect (branch/jump/trap).

Parameters:
- DEPTH, 16, queue capacity in 32-bit words; power of 2, minimum 8.
- RESET_PC, 32'h0000_0000, fetch and issue PC after reset.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals fetch_pc register.
- imem_w0..imem_w7  in  32 each  words at imem_addr/4 + 0..7; memory is combinational, same cycle.
- redirect  in  1  flush queue and restart fetch.
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 00).
- dec_valid  out  1  queue head holds a valid instruction.
- dec_ready  in  1  decode accepts the head this cycle.
- dec_instr  out  32  instruction at queue head.
- dec_pc  out  32  byte address of dec_instr.
- count  out  $clog2(DEPTH)+1  occupied words, for debug and perf.

Behaviour:
- State:
  - fetch_pc (32)
  - head_pc (32)
  - head/tail pointers (log2 DEPTH)
  - count
  - word storage DEPTH x 32
- Reset (RST=1 at edge):
  - fetch_pc = head_pc = RESET_PC; head = tail = 0; count = 0.
  - Outputs: dec_valid = 0, imem_addr = RESET_PC.
  - Storage contents are don't-care.
  - RST overrides redirect and every other input, including mid-fill and mid-drain.
- fill = (count <= DEPTH-8) && !redirect, using the registered count.
- When fill=1:
  - imem_w0..w7 are written to tail..tail+7, mod DEPTH.
  - tail += 8; fetch_pc += 32.
- fetch_pc is not required to be line-aligned.
- pop = dec_valid && dec_ready. On pop: head += 1, head_pc += 4.
- dec_valid = (count != 0) && !redirect. dec_instr = storage[head], dec_pc = head_pc; both combinational from registers.
- Simultaneous fill and pop: count_next = count + 8 - 1. Fill alone: +8. Pop alone: -1.
- Full boundary:
  - With count > DEPTH-8, no fill occurs and imem_addr holds.
  - count never exceeds DEPTH.
  - Fill eligibility ignores the same-cycle pop (conservative; no combinational path from dec_ready to imem_addr).
- Empty boundary: dec_valid=0 and dec_ready is ignored.
- Redirect=1 at edge:
  - head = tail = 0; count = 0.
  - fetch_pc = head_pc = {redirect_pc[31:2],2'b00}.
  - No fill and no pop that cycle; dec_valid is forced to 0 in that cycle.
- Latency:
  - After reset or redirect, the first fill happens in the next cycle.
  - dec_valid rises one cycle after that fill: 2 cycles from the deassertion edge of RST/redirect to the first issue.
  - Steady state: one instruction per cycle, no bubbles while decode is ready.
- Wrap:
  - Pointers wrap modulo DEPTH.
  - fetch_pc and head_pc wrap modulo 2^32 with no error.
- Branch prediction and compressed instructions are out of scope. All instructions are 32-bit and sequential.

Decomposition:
- Shared package fetch_pkg:
  - LINE_WORDS = 8
  - typedef word_t (logic [31:0])
  - typedef fetch_line_t (word_t [LINE_WORDS-1:0])
- One sub-module fetch_queue:
  - parameterised circular storage with an 8-wide write port and a 1-wide read port
  - owns head, tail and count
- fetch_buffer keeps fetch_pc, head_pc, fill/pop logic and the redirect logic.

Test Plan:
1. Memory word i = 32'h1000_0000+i, dec_ready=1, release RST.
   - 2nd cycle after release: dec_valid=1, dec_pc=0, dec_instr=32'h1000_0000.
   - Then dec_pc 4, 8, 12... with matching words, every cycle, no bubble, for 40 instructions (covers pointer wrap).
2. dec_ready=0 after reset.
   - count goes 8 then 16 and stops; imem_addr holds at 0x40.
   - Raising dec_ready yields words 0..15 in order; a refill at 0x40 occurs once count <= 8.
3. count=8, dec_valid=1, dec_ready=1 in one cycle → count=15 next cycle; head advances by 1, tail by 8.
4. count=12, pulse redirect with redirect_pc=0x107.
   - Redirect cycle: dec_valid=0.
   - Next cycle: count=0, imem_addr=0x104.
   - Following cycle: dec_valid=1, dec_pc=0x104, dec_instr=word 0x41.
5. RST asserted while count=10 and redirect=1 → next cycle count=0, imem_addr=RESET_PC, dec_valid=0.
6. Random dec_ready (50%) over 500 cycles.
   - Scoreboard: issued dec_pc strictly sequential by 4, dec_instr = mem[dec_pc/4].
   - count never exceeds 16.
